// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and constants used by the pooled output writer.
package cnn_pkg;

  localparam int unsigned POOL_VEC_N = 4;
  localparam int unsigned PACK_LANES = 4;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    FLUSH,
    DONE
  } pool_state_t;

  typedef logic [7:0] pixel_t;

endpackage

// File: rtl/pool_writer_if.sv
// Handshake and output-memory bus between the post-sum shift register, the controller and pool_writer.
interface pool_writer_if
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned VEC_N  = POOL_VEC_N,
  parameter int unsigned ADDR_W = 8
) ();

  logic                             start;
  logic                             inValid;
  logic                             inReady;
  logic [DATA_W-1:0]                inData [VEC_N];
  logic                             outWrEn;
  logic [ADDR_W-1:0]                outAddr;
  logic [PACK_LANES*DATA_W-1:0]     outWrData;
  logic                             busy;
  logic                             done;

  modport master (
    output start, inValid, inData,
    input  inReady, outWrEn, outAddr, outWrData, busy, done
  );

  modport slave (
    input  start, inValid, inData,
    output inReady, outWrEn, outAddr, outWrData, busy, done
  );

endinterface

// File: rtl/pool_writer_max4.sv
// Combinational unsigned 4:1 max tree for one 2x2 pooling window.
module pool_writer_max4
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_d [POOL_VEC_N],
  output logic [DATA_W-1:0] o_max_c
);

  logic [DATA_W-1:0] w_lo;
  logic [DATA_W-1:0] w_hi;

  assign w_lo    = (i_d[0] > i_d[1]) ? i_d[0] : i_d[1];
  assign w_hi    = (i_d[2] > i_d[3]) ? i_d[2] : i_d[3];
  assign o_max_c = (w_lo > w_hi) ? w_lo : w_hi;

endmodule

// File: rtl/pool_writer.sv
// Max-pools incoming 4-element vectors, packs four results per 32-bit word and
// writes them to the output feature map with an auto-incrementing address.
module pool_writer
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_OUT   = 16,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  pool_writer_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(NUM_OUT + 1);
  localparam int unsigned LANE_W = $clog2(PACK_LANES);
  localparam int unsigned WORD_W = PACK_LANES * DATA_W;

  pool_state_t                          r_state;
  logic [CNT_W-1:0]                     r_accept_cnt;
  logic                                 r_drain_cnt;
  logic [LANE_W-1:0]                    r_lane;
  logic [ADDR_W-1:0]                    r_wr_addr;
  logic [PACK_LANES-1:0][DATA_W-1:0]    r_pack;
  logic [DATA_W-1:0]                    r_pool;
  logic                                 r_pool_vld;
  logic                                 r_in_ready;
  logic                                 r_wr_en;
  logic [ADDR_W-1:0]                    r_out_addr;
  logic [WORD_W-1:0]                    r_wr_data;
  logic                                 r_busy;
  logic                                 r_done;

  logic [DATA_W-1:0]                    w_vec [POOL_VEC_N];
  logic [DATA_W-1:0]                    w_max;
  logic                                 w_accept;

  assign w_vec    = bus.inData;
  assign w_accept = bus.inValid && r_in_ready;

  pool_writer_max4 #(.DATA_W(DATA_W)) u_max4 (
    .i_d     (w_vec),
    .o_max_c (w_max)
  );

  // Control FSM plus the two-stage pool/pack pipeline; the pipeline runs independently of state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_accept_cnt <= '0;
      r_drain_cnt  <= 1'b0;
      r_lane       <= '0;
      r_wr_addr    <= '0;
      r_pack       <= '0;
      r_pool       <= '0;
      r_pool_vld   <= 1'b0;
      r_in_ready   <= 1'b0;
      r_wr_en      <= 1'b0;
      r_out_addr   <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_wr_en    <= 1'b0;
      r_done     <= (r_state == DONE);
      r_pool_vld <= w_accept;
      if (w_accept) begin
        r_pool <= w_max;
      end

      if (r_pool_vld) begin
        if (r_lane == LANE_W'(PACK_LANES - 1)) begin
          r_wr_en    <= 1'b1;
          r_out_addr <= r_wr_addr;
          r_wr_data  <= {r_pool, r_pack[PACK_LANES-2:0]};
          r_pack     <= '0;
          r_wr_addr  <= r_wr_addr + ADDR_W'(1);
          r_lane     <= '0;
        end else begin
          r_pack[r_lane] <= r_pool;
          r_lane         <= r_lane + LANE_W'(1);
        end
      end

      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state      <= RUN;
            r_accept_cnt <= '0;
            r_lane       <= '0;
            r_pack       <= '0;
            r_wr_addr    <= ADDR_W'(BASE_ADDR);
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        RUN: begin
          if (w_accept) begin
            r_accept_cnt <= r_accept_cnt + CNT_W'(1);
            if (r_accept_cnt == CNT_W'(NUM_OUT - 1)) begin
              r_state     <= DRAIN;
              r_in_ready  <= 1'b0;
              r_drain_cnt <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Two cycles let the last accepted vector reach the pack register.
          r_drain_cnt <= 1'b1;
          if (r_drain_cnt) begin
            r_state <= (r_lane != '0) ? FLUSH : DONE;
          end
        end
        FLUSH: begin
          // Upper lanes of r_pack are already zero from the last full-word clear.
          r_wr_en    <= 1'b1;
          r_out_addr <= r_wr_addr;
          r_wr_data  <= r_pack;
          r_wr_addr  <= r_wr_addr + ADDR_W'(1);
          r_state    <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.inReady   = r_in_ready;
  assign bus.outWrEn   = r_wr_en;
  assign bus.outAddr   = r_out_addr;
  assign bus.outWrData = r_wr_data;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_pool_writer.sv
// Randomized bench for pool_writer: two configurations share stimulus and are
// checked cycle by cycle against an event-scheduled reference model.
module tb_pool_writer;
  import cnn_pkg::*;

  localparam int unsigned MAXC = 4096;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   start = 1'b0;
  logic   in_valid = 1'b0;
  pixel_t in_data [4];

  always #5 clk = ~clk;

  pool_writer_if #(.DATA_W(8), .VEC_N(4), .ADDR_W(2)) bus0 ();
  pool_writer_if #(.DATA_W(8), .VEC_N(4), .ADDR_W(8)) bus1 ();

  assign bus0.start   = start;
  assign bus0.inValid = in_valid;
  assign bus0.inData  = in_data;
  assign bus1.start   = start;
  assign bus1.inValid = in_valid;
  assign bus1.inData  = in_data;

  // Config 0: partial flush and address wrap. Config 1: single full word, no flush.
  pool_writer #(.DATA_W(8), .NUM_OUT(6), .ADDR_W(2), .BASE_ADDR(3)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0.slave)
  );
  pool_writer #(.DATA_W(8), .NUM_OUT(4), .ADDR_W(8), .BASE_ADDR(16)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave)
  );

  logic        o_rdy  [2];
  logic        o_busy [2];
  logic        o_done [2];
  logic        o_wr   [2];
  logic [7:0]  o_addr [2];
  logic [31:0] o_data [2];

  assign o_rdy[0]  = bus0.inReady;
  assign o_busy[0] = bus0.busy;
  assign o_done[0] = bus0.done;
  assign o_wr[0]   = bus0.outWrEn;
  assign o_addr[0] = {6'b0, bus0.outAddr};
  assign o_data[0] = bus0.outWrData;
  assign o_rdy[1]  = bus1.inReady;
  assign o_busy[1] = bus1.busy;
  assign o_done[1] = bus1.done;
  assign o_wr[1]   = bus1.outWrEn;
  assign o_addr[1] = bus1.outAddr;
  assign o_data[1] = bus1.outWrData;

  int unsigned num_out [2] = '{6, 4};
  int unsigned base    [2] = '{3, 16};
  int unsigned amask   [2] = '{3, 255};

  bit          exp_rdy  [2][MAXC];
  bit          exp_busy [2][MAXC];
  bit          exp_done [2][MAXC];
  bit          exp_wr   [2][MAXC];
  bit          exp_clr  [2][MAXC];
  logic [7:0]  exp_addr [2][MAXC];
  logic [31:0] exp_data [2][MAXC];

  logic [7:0]  m_last_addr [2] = '{8'h00, 8'h00};
  logic [31:0] m_last_data [2] = '{32'h0, 32'h0};
  int unsigned m_cnt [2] = '{0, 0};
  logic [7:0]  m_pool [2][16];

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] first_wr1;
  bit          seen_wr1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_word(int d, int first, int n);
    logic [31:0] w = 32'h0;
    for (int k = 0; k < n; k++) w |= 32'(m_pool[d][first + k]) << (8 * k);
    return w;
  endfunction

  task automatic check_cycle();
    for (int d = 0; d < 2; d++) begin
      if (exp_clr[d][cyc]) begin
        m_last_addr[d] = 8'h00;
        m_last_data[d] = 32'h0;
      end
      if (exp_wr[d][cyc]) begin
        m_last_addr[d] = exp_addr[d][cyc];
        m_last_data[d] = exp_data[d][cyc];
      end
      chk($sformatf("d%0d_ready", d), 32'(o_rdy[d]),  32'(exp_rdy[d][cyc]));
      chk($sformatf("d%0d_busy", d),  32'(o_busy[d]), 32'(exp_busy[d][cyc]));
      chk($sformatf("d%0d_done", d),  32'(o_done[d]), 32'(exp_done[d][cyc]));
      chk($sformatf("d%0d_wren", d),  32'(o_wr[d]),   32'(exp_wr[d][cyc]));
      chk($sformatf("d%0d_addr", d),  32'(o_addr[d]), 32'(m_last_addr[d]));
      chk($sformatf("d%0d_data", d),  o_data[d],      m_last_data[d]);
    end
    if (o_wr[1] === 1'b1 && !seen_wr1) begin
      seen_wr1  = 1'b1;
      first_wr1 = o_data[1];
    end
  endtask

  // Reference model: schedules the visible consequences of each cycle's inputs.
  task automatic model(input logic st, input logic vl, input logic rs);
    logic [7:0] mx;
    int unsigned c = cyc;
    for (int d = 0; d < 2; d++) begin
      if (rs) begin
        for (int i = c + 1; i <= c + 6; i++) begin
          exp_rdy[d][i] = 0; exp_busy[d][i] = 0; exp_done[d][i] = 0;
          exp_wr[d][i] = 0;  exp_clr[d][i] = 0;
        end
        exp_clr[d][c + 1] = 1;
        m_cnt[d] = 0;
      end else if (st && !exp_busy[d][c]) begin
        m_cnt[d] = 0;
        exp_busy[d][c + 1] = 1;
        exp_rdy[d][c + 1]  = 1;
      end else if (exp_rdy[d][c]) begin
        if (vl) begin
          mx = 8'h00;
          for (int k = 0; k < 4; k++) if (in_data[k] > mx) mx = in_data[k];
          m_pool[d][m_cnt[d]] = mx;
          m_cnt[d]++;
          if (m_cnt[d] % 4 == 0) begin
            exp_wr[d][c + 2]   = 1;
            exp_addr[d][c + 2] = 8'((base[d] + m_cnt[d] / 4 - 1) & amask[d]);
            exp_data[d][c + 2] = pack_word(d, int'(m_cnt[d]) - 4, 4);
          end
          if (m_cnt[d] == num_out[d]) begin
            for (int i = c + 1; i <= c + 3; i++) exp_busy[d][i] = 1;
            if (num_out[d] % 4 != 0) begin
              exp_wr[d][c + 4]   = 1;
              exp_addr[d][c + 4] = 8'((base[d] + num_out[d] / 4) & amask[d]);
              exp_data[d][c + 4] = pack_word(d, int'(num_out[d] / 4 * 4), int'(num_out[d] % 4));
              exp_busy[d][c + 4] = 1;
              exp_done[d][c + 5] = 1;
            end else begin
              exp_done[d][c + 4] = 1;
            end
          end else begin
            exp_rdy[d][c + 1]  = 1;
            exp_busy[d][c + 1] = 1;
          end
        end else begin
          exp_rdy[d][c + 1]  = 1;
          exp_busy[d][c + 1] = 1;
        end
      end
    end
  endtask

  task automatic step(input logic st, input logic vl, input logic rs, input logic [31:0] dw);
    @(negedge clk);
    if (cyc > 0) check_cycle();
    start    = st;
    in_valid = vl;
    rst      = rs;
    for (int k = 0; k < 4; k++) in_data[k] = dw[8*k +: 8];
    model(st, vl, rs);
    cyc++;
    if (cyc >= int'(MAXC) - 8) begin
      $display("FAIL cycle_budget got=%0d exp<%0d", cyc, MAXC - 8);
      $fatal(1);
    end
  endtask

  // mode 0: valid always high; 1: valid pattern 1,0,0; 2: random valid plus starts while busy
  task automatic run_until_idle(input int mode);
    int  i = 0;
    logic vl, st;
    while ((exp_busy[0][cyc] || exp_busy[1][cyc]) && i < 200) begin
      vl = (mode == 0) ? 1'b1 : (mode == 1) ? logic'(i % 3 == 0) : logic'($urandom_range(0, 1));
      st = (mode == 2 && exp_busy[0][cyc] && exp_busy[1][cyc]) ? logic'($urandom_range(0, 5) == 0) : 1'b0;
      step(st, vl, 1'b0, $urandom);
      i++;
    end
    if (i >= 200) chk("idle_timeout", 32'(i), 32'd0);
    step(1'b0, 1'b1, 1'b0, $urandom);
    step(1'b0, 1'b0, 1'b0, $urandom);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) in_data[k] = 8'h00;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, $urandom);
    step(1'b0, 1'b0, 1'b0, 32'h0);

    // Directed vectors, back to back
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h02030901);
    step(1'b0, 1'b1, 1'b0, 32'hFF0007C8);
    step(1'b0, 1'b1, 1'b0, 32'h04040404);
    step(1'b0, 1'b1, 1'b0, 32'h01000000);
    run_until_idle(0);
    chk("basic_word", first_wr1, 32'h0104FF09);

    // Throttled input
    step(1'b1, 1'b0, 1'b0, $urandom);
    run_until_idle(1);

    // Reset after three accepts, then a clean run
    step(1'b1, 1'b0, 1'b0, $urandom);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, $urandom);
    step(1'b0, 1'b1, 1'b1, $urandom);
    step(1'b0, 1'b1, 1'b0, $urandom);
    step(1'b0, 1'b0, 1'b0, $urandom);
    step(1'b1, 1'b0, 1'b0, $urandom);
    run_until_idle(0);

    // Random runs with spurious starts while busy
    for (int r = 0; r < 20; r++) begin
      step(1'b1, logic'($urandom_range(0, 1)), 1'b0, $urandom);
      run_until_idle(2);
    end

    step(1'b0, 1'b0, 1'b0, 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
